axil_iram_slave: RTL

- AXI4-Lite responder (slave) terminating the core's `iram_axi_*` master port.
- Backs the port with an on-chip word-addressed RAM of DEPTH words.
- Serialises reads and writes through one FSM, one transaction at a time.
- Returns OKAY for in-range accesses and SLVERR for out-of-range addresses.

---
 rtl/axil_iram_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axil_iram_slave.sv
// AXI4-Lite responder backed by an on-chip word RAM; one transaction at a time.
// Latency: ready in the cycle after a request is seen in IDLE, response valid one cycle later.
// Backpressure: B/R responses hold stable until bready/rready; new requests wait in IDLE meanwhile.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b* write address, write data, write response channels
//   s_axi_ar*/s_axi_r*          read address, read data channels
//   awprot/arprot are accepted but ignored.
module axil_iram_slave #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [1:0]        OKAY    = 2'b00;
  localparam logic [1:0]        SLVERR  = 2'b10;

  typedef enum logic [2:0] {IDLE, W_ACC, B_RESP, R_ACC, R_RESP} state_t;

  state_t state_q, state_d;
  logic   rd_first_q, rd_first_d;   // round-robin flag: 1 = read wins the next tie
  logic   wr_req, rd_req;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] acc_addr, acc_off;
  logic              acc_hit;
  logic [IDX_W-1:0]  acc_idx;
  logic              unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  // A write needs both AW and W in the same cycle; lone AW or W is never taken.
  assign wr_req = s_axi_awvalid && s_axi_wvalid;
  assign rd_req = s_axi_arvalid;

  // Only one access phase is ever active, so a single decoder serves both channels.
  assign acc_addr = (state_q == W_ACC) ? s_axi_awaddr : s_axi_araddr;
  assign acc_off  = acc_addr - BASE;
  assign acc_hit  = (acc_addr >= BASE) && ((acc_off >> 2) < DEPTH_A);
  assign acc_idx  = acc_off[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_first_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_first_q <= rd_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_first_d = rd_first_q;
    case (state_q)
      IDLE: begin
        if (wr_req && rd_req) begin
          state_d    = rd_first_q ? R_ACC : W_ACC;
          rd_first_d = !rd_first_q;
        end else if (wr_req) begin
          state_d = W_ACC;
        end else if (rd_req) begin
          state_d = R_ACC;
        end
      end
      W_ACC:   state_d = B_RESP;
      B_RESP:  if (s_axi_bready) state_d = IDLE;
      R_ACC:   state_d = R_RESP;
      R_RESP:  if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range writes are dropped; only enabled byte lanes change.
  always_ff @(posedge clk) begin
    if (state_q == W_ACC && acc_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[acc_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // All handshake outputs are flops decoded from the next state, so each is
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= (state_d == W_ACC);
      s_axi_wready  <= (state_d == W_ACC);
      s_axi_arready <= (state_d == R_ACC);
      s_axi_bvalid  <= (state_d == B_RESP);
      s_axi_rvalid  <= (state_d == R_RESP);
      if (state_q == W_ACC) begin
        s_axi_bresp <= acc_hit ? OKAY : SLVERR;
      end
      // rdata is only updated here, so it stays put after the R handshake.
      if (state_q == R_ACC) begin
        s_axi_rresp <= acc_hit ? OKAY : SLVERR;
        s_axi_rdata <= acc_hit ? mem[acc_idx] : '0;
      end
    end
  end

endmodule
